// File: rtl/store_buffer_unit_if.sv
// Store-buffer port bundle: M-stage store/load side plus the write-bus side.
// The slave modport is the buffer; the master modport is the pipeline/bus environment.
interface store_buffer_unit_if;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_stall;
    logic        exc_ades;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic        ld_conflict;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_ack;
    logic        drained;

    modport slave (
        input  st_op, st_addr, st_wdata, ld_addr, ld_valid, m_ack,
        output st_stall, exc_ades, ld_conflict, m_req, m_addr, m_wdata, m_byteen, drained
    );

    modport master (
        output st_op, st_addr, st_wdata, ld_addr, ld_valid, m_ack,
        input  st_stall, exc_ades, ld_conflict, m_req, m_addr, m_wdata, m_byteen, drained
    );
endinterface

// File: rtl/store_buffer_unit.sv
// MEM-stage store buffer: aligns/encodes stores, queues them, drains head via m_req/m_ack.
// Head visible one cycle after push; st_stall while full, and a full buffer refuses pushes even on a pop cycle.
module store_buffer_unit #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    store_buffer_unit_if.slave bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SB   = 2'b01;
    localparam logic [1:0] OP_SH   = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [DEPTH-1:0] r_valid;
    logic [29:0]      r_waddr [DEPTH];
    logic [31:0]      r_data  [DEPTH];
    logic [3:0]       r_ben   [DEPTH];

    logic        w_misaligned;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_enc_ben;
    logic [31:0] w_enc_data;
    logic        w_hit;

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.st_op)
            OP_SH:   w_misaligned = bus.st_addr[0];
            OP_SW:   w_misaligned = (bus.st_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Data is lane-replicated so the bus can take whichever lanes byteen selects.
    always_comb begin
        w_enc_ben  = 4'b0000;
        w_enc_data = 32'h0;
        case (bus.st_op)
            OP_SB: begin
                w_enc_ben  = 4'b0001 << bus.st_addr[1:0];
                w_enc_data = {4{bus.st_wdata[7:0]}};
            end
            OP_SH: begin
                w_enc_ben  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                w_enc_data = {2{bus.st_wdata[15:0]}};
            end
            OP_SW: begin
                w_enc_ben  = 4'b1111;
                w_enc_data = bus.st_wdata;
            end
            default: begin
                w_enc_ben  = 4'b0000;
                w_enc_data = 32'h0;
            end
        endcase
    end

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = (bus.st_op != OP_NONE) && !w_misaligned && !w_full;
    assign w_pop   = !w_empty && bus.m_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
        end else begin
            // Push and pop never touch the same slot: wr==rd only when empty or full.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_wr_ptr] <= bus.st_addr[31:2];
            r_data[r_wr_ptr]  <= w_enc_data;
            r_ben[r_wr_ptr]   <= w_enc_ben;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_waddr[i] == bus.ld_addr[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign bus.exc_ades    = w_misaligned;
    assign bus.st_stall    = w_full;
    assign bus.drained     = w_empty;
    assign bus.ld_conflict = bus.ld_valid && w_hit;
    assign bus.m_req       = !w_empty;
    assign bus.m_addr      = w_empty ? 32'h0 : {r_waddr[r_rd_ptr], 2'b00};
    assign bus.m_wdata     = w_empty ? 32'h0 : r_data[r_rd_ptr];
    assign bus.m_byteen    = w_empty ? 4'b0000 : r_ben[r_rd_ptr];
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit with a FIFO scoreboard of expected bus writes.
module tb_store_buffer_unit;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_unit_if sbif();

    store_buffer_unit #(.DEPTH(2), .PTR_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbif.slave)
    );

    ent_t        sb[$];
    logic [31:0] bus_order[$];
    int          mcount;
    int          checks;
    int          errors;

    function automatic logic mis(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'b10) return a[0];
        if (op == 2'b11) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic ent_t enc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.addr = {a[31:2], 2'b00};
        case (op)
            2'b01: begin
                e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a[1:0])
                    2'd0: e.ben = 4'b0001;
                    2'd1: e.ben = 4'b0010;
                    2'd2: e.ben = 4'b0100;
                    default: e.ben = 4'b1000;
                endcase
            end
            2'b10: begin
                e.data = {d[15:0], d[15:0]};
                e.ben  = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.data = d;
                e.ben  = 4'b1111;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, then advance the model at posedge.
    task automatic tick();
        logic do_push;
        logic do_pop;
        ent_t e;
        @(negedge clk);
        chk("m_req", {31'b0, sbif.m_req}, {31'b0, mcount != 0});
        if (mcount > 0) begin
            chk("m_addr", sbif.m_addr, sb[0].addr);
            chk("m_wdata", sbif.m_wdata, sb[0].data);
            chk("m_byteen", {28'b0, sbif.m_byteen}, {28'b0, sb[0].ben});
        end else begin
            chk("m_addr_idle", sbif.m_addr, 32'h0);
            chk("m_byteen_idle", {28'b0, sbif.m_byteen}, 32'h0);
        end
        chk("st_stall", {31'b0, sbif.st_stall}, {31'b0, mcount == 2});
        chk("drained", {31'b0, sbif.drained}, {31'b0, mcount == 0});
        chk("exc_ades", {31'b0, sbif.exc_ades}, {31'b0, mis(sbif.st_op, sbif.st_addr)});
        do_push = !reset && (sbif.st_op != 2'b00) && !mis(sbif.st_op, sbif.st_addr) && (mcount < 2);
        do_pop  = !reset && (mcount > 0) && sbif.m_ack;
        if (!reset && sbif.m_req && sbif.m_ack) bus_order.push_back(sbif.m_addr);
        e = enc(sbif.st_op, sbif.st_addr, sbif.st_wdata);
        @(posedge clk);
        #1;
        if (reset) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                mcount--;
            end
            if (do_push) begin
                sb.push_back(e);
                mcount++;
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        sbif.st_op    = op;
        sbif.st_addr  = a;
        sbif.st_wdata = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mcount = 0;
        reset  = 1'b1;
        drive(2'b00, 32'h0, 32'h0);
        sbif.ld_addr  = 32'h0;
        sbif.ld_valid = 1'b0;
        sbif.m_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", {31'b0, sbif.m_req}, 32'h0);
        chk("rst_drained", {31'b0, sbif.drained}, 32'h1);
        chk("rst_stall", {31'b0, sbif.st_stall}, 32'h0);
        chk("rst_m_addr", sbif.m_addr, 32'h0);
        chk("rst_m_wdata", sbif.m_wdata, 32'h0);
        chk("rst_m_byteen", {28'b0, sbif.m_byteen}, 32'h0);
        reset = 1'b0;

        // SW into empty buffer with ack held: visible next cycle, popped one later
        sbif.m_ack = 1'b1;
        drive(2'b11, 32'h0000_1004, 32'hDEAD_BEEF);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("sw_req", {31'b0, sbif.m_req}, 32'h1);
        chk("sw_addr", sbif.m_addr, 32'h0000_1004);
        chk("sw_ben", {28'b0, sbif.m_byteen}, 32'hF);
        chk("sw_data", sbif.m_wdata, 32'hDEAD_BEEF);
        tick();
        chk("sw_drained", {31'b0, sbif.drained}, 32'h1);

        // SB and SH lane encoding
        drive(2'b01, 32'h0000_2003, 32'h0000_00A5);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("sb_ben", {28'b0, sbif.m_byteen}, 32'h8);
        chk("sb_data", sbif.m_wdata, 32'hA5A5_A5A5);
        tick();
        drive(2'b10, 32'h0000_2002, 32'h0000_1234);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("sh_ben", {28'b0, sbif.m_byteen}, 32'hC);
        chk("sh_data", sbif.m_wdata, 32'h1234_1234);
        chk("sh_addr", sbif.m_addr, 32'h0000_2000);
        tick();

        // Misaligned stores raise exc_ades and are dropped
        drive(2'b11, 32'h0000_3002, 32'h1111_1111);
        #1;
        chk("ades_sw", {31'b0, sbif.exc_ades}, 32'h1);
        tick();
        drive(2'b10, 32'h0000_3001, 32'h2222_2222);
        #1;
        chk("ades_sh", {31'b0, sbif.exc_ades}, 32'h1);
        tick();
        drive(2'b01, 32'h0000_3003, 32'h0);
        #1;
        chk("sb_never_ades", {31'b0, sbif.exc_ades}, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        tick();
        chk("ades_no_req", {31'b0, sbif.m_req}, 32'h0);

        // Full buffer: third push refused even on the pop cycle, retried next
        bus_order.delete();
        sbif.m_ack = 1'b0;
        drive(2'b11, 32'h10, 32'hA0);
        tick();
        drive(2'b11, 32'h14, 32'hA1);
        tick();
        chk("full_stall", {31'b0, sbif.st_stall}, 32'h1);
        drive(2'b11, 32'h18, 32'hA2);
        tick();
        chk("full_hold_head", sbif.m_addr, 32'h10);
        sbif.m_ack = 1'b1;
        tick();
        sbif.m_ack = 1'b0;
        chk("pop_no_stall", {31'b0, sbif.st_stall}, 32'h0);
        chk("pop_head", sbif.m_addr, 32'h14);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("retry_full", {31'b0, sbif.st_stall}, 32'h1);
        sbif.m_ack = 1'b1;
        repeat (3) tick();
        chk("order_cnt", bus_order.size(), 32'd3);
        if (bus_order.size() == 3) begin
            chk("order0", bus_order[0], 32'h10);
            chk("order1", bus_order[1], 32'h14);
            chk("order2", bus_order[2], 32'h18);
        end

        // Back-to-back throughput with ack held
        bus_order.delete();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 32'h0000_6000 + 32'(i), 32'h50 + 32'(i));
            tick();
        end
        drive(2'b00, 32'h0, 32'h0);
        tick();
        chk("tput_cnt", bus_order.size(), 32'd4);
        chk("tput_drained", {31'b0, sbif.drained}, 32'h1);

        // Load conflict against pending entry
        sbif.m_ack = 1'b0;
        drive(2'b11, 32'h0000_4000, 32'h1);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h0000_4003;
        #1;
        chk("conf_hit", {31'b0, sbif.ld_conflict}, 32'h1);
        sbif.ld_addr = 32'h0000_4004;
        #1;
        chk("conf_miss", {31'b0, sbif.ld_conflict}, 32'h0);
        sbif.ld_addr  = 32'h0000_4003;
        sbif.ld_valid = 1'b0;
        #1;
        chk("conf_noload", {31'b0, sbif.ld_conflict}, 32'h0);
        sbif.ld_valid = 1'b1;
        sbif.m_ack    = 1'b1;
        tick();
        sbif.m_ack = 1'b0;
        chk("conf_clear", {31'b0, sbif.ld_conflict}, 32'h0);
        sbif.ld_valid = 1'b0;

        // Reset mid-stream discards pending stores
        drive(2'b11, 32'h0000_5000, 32'h77);
        tick();
        drive(2'b10, 32'h0000_5006, 32'h88);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("pre_rst_stall", {31'b0, sbif.st_stall}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_req", {31'b0, sbif.m_req}, 32'h0);
        chk("mrst_drained", {31'b0, sbif.drained}, 32'h1);
        chk("mrst_addr", sbif.m_addr, 32'h0);
        chk("mrst_data", sbif.m_wdata, 32'h0);
        chk("mrst_ben", {28'b0, sbif.m_byteen}, 32'h0);
        sbif.m_ack = 1'b1;
        tick();
        chk("end_drained", {31'b0, sbif.drained}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Write-side companion to the load data extender in the MEM stage.
- Takes store requests from the M stage, checks alignment, and generates byte enables and lane-replicated write data.
- Queues accepted stores in a small FIFO and drains them to the data bus through a req/ack handshake.
- Raises a stall when full, and flags pending-store conflicts for loads so a load never reads stale memory.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2).
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- st_op  input  2  store type: 00 none, 01 SB, 10 SH, 11 SW
- st_addr  input  32  byte address of store
- st_wdata  input  32  register data (low bits used for SB/SH)
- st_stall  output  1  buffer full; M stage must hold the store
- exc_ades  output  1  misaligned store (combinational)
- ld_addr  input  32  address of load currently in M stage
- ld_valid  input  1  a load is in M stage
- ld_conflict  output  1  a buffered entry matches ld_addr word (combinational)
- m_req  output  1  bus write request
- m_addr  output  32  word-aligned bus address
- m_wdata  output  32  lane-replicated write data
- m_byteen  output  4  byte enables
- m_ack  input  1  bus accepted the head entry this cycle
- drained  output  1  buffer empty

Behaviour:
- Reset (sync, active-high) values: count=0, pointers=0, m_req=0, m_addr=0, m_wdata=0, m_byteen=0, st_stall=0, drained=1.
- Alignment check:
  - exc_ades=1 when st_op=SH and st_addr[0]=1.
  - exc_ades=1 when st_op=SW and st_addr[1:0]≠0.
  - SB is never misaligned.
  - A misaligned store is never enqueued.
- Encoding at enqueue:
  - SB: byteen=4'b0001<<st_addr[1:0]; data={4{st_wdata[7:0]}}.
  - SH: byteen=st_addr[1]?4'b1100:4'b0011; data={2{st_wdata[15:0]}}.
  - SW: byteen=4'b1111; data=st_wdata.
  - Stored address={st_addr[31:2],2'b00}.
- Push: occurs on a clock edge when st_op≠00, exc_ades=0, and count<DEPTH.
- Full case:
  - st_stall = (count==DEPTH), registered-state based.
  - A push is refused while full, even if a pop happens in the same cycle; the store is retried next cycle.
- Bus head outputs:
  - m_req=1 whenever count>0.
  - m_addr, m_wdata and m_byteen always reflect the head entry.
  - These outputs are zero when empty.
- Pop: occurs on an edge where m_req=1 and m_ack=1.
  - m_ack while m_req=0 is ignored.
  - Head outputs hold stable until acked.
- Simultaneous push and pop with count<DEPTH: count is unchanged and both pointers advance.
- Latency: a store pushed into an empty buffer presents m_req=1 on the cycle after the push edge. With m_ack held 1, throughput is one store per cycle.
- Pointers wrap modulo DEPTH. Order is strict FIFO.
- ld_conflict = ld_valid and (any valid entry's word address == ld_addr[31:2]). It does not include the store being pushed in the same cycle; the pipeline guarantees stores and loads are not co-resident in M.
- drained = (count==0).
- Reset mid-operation: all buffered stores are discarded, and m_req drops on the next cycle.

Test Plan:
- Reset, then SW addr=0x0000_1004 data=0xDEADBEEF, m_ack=1 -> next cycle m_req=1, m_addr=0x1004, m_byteen=1111, m_wdata=0xDEADBEEF; popped one cycle later, drained=1.
- SB addr=0x2003 data=0x000000A5 -> m_byteen=1000, m_wdata=0xA5A5A5A5. SH addr=0x2002 data=0x1234 -> m_byteen=1100, m_wdata=0x12341234.
- SW addr=0x3002, then SH addr=0x3001 -> exc_ades=1 in each cycle; no entries enqueued; m_req stays 0.
- m_ack=0; push 0x10, 0x14, then 0x18 -> st_stall=1 after two pushes; third not accepted. Raise m_ack for one cycle -> 0x10 pops; 0x18 accepted the following cycle; order seen on bus is 0x10, 0x14, 0x18.
- Entry at 0x4000 pending, ld_valid=1, ld_addr=0x4003 -> ld_conflict=1; ld_addr=0x4004 -> 0. After ack, conflict with 0x4003 clears.
- Two entries pending, assert reset for one cycle mid-stream -> m_req=0, drained=1, all bus outputs 0 on the next cycle.
